twos_to_adc_offset: RTL and testbench

//  Converts W-bit two's-complement samples to ADC/DAC offset-binary code (and back) for the SPGD

---
 rtl/twos_to_adc_offset_pkg.sv | 31 +++
 rtl/twos_to_adc_offset_sat_negate.sv | 24 ++
 rtl/twos_to_adc_offset.sv | 76 +++++++
 tb/tb_twos_to_adc_offset.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/twos_to_adc_offset_pkg.sv
// Shared helpers for the two's-complement / offset-binary converter.
// Width-generic masks are built at elaboration from 64-bit helpers.
package twos_to_adc_offset_pkg;

  localparam int MAX_W  = 64;
  localparam int SPGD_W = 14;

  typedef enum logic {
    DIR_TO_OFFSET = 1'b0,
    DIR_TO_TWOS   = 1'b1
  } dir_e;

  function automatic logic [MAX_W-1:0] msb_flip(
    input logic [MAX_W-1:0] x,
    input int               w
  );
    return x ^ (64'd1 << (w - 1));
  endfunction

  function automatic logic [MAX_W-1:0] min_s(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] max_s(input int w);
    return min_s(w) - 64'd1;
  endfunction

  localparam logic [SPGD_W-1:0] MIN_S = {1'b1, {(SPGD_W-1){1'b0}}};
  localparam logic [SPGD_W-1:0] MAX_S = {1'b0, {(SPGD_W-1){1'b1}}};

endpackage

// File: rtl/twos_to_adc_offset_sat_negate.sv
// Saturating two's-complement negation; the most-negative code
// maps to the most-positive one and raises o_sat.
module twos_to_adc_offset_sat_negate
  import twos_to_adc_offset_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0] i_s,
  output logic [W-1:0] o_n,
  output logic         o_sat
);

  localparam logic [MAX_W-1:0] MIN64 = min_s(W);
  localparam logic [MAX_W-1:0] MAX64 = max_s(W);
  localparam logic [W-1:0]     MIN_V = MIN64[W-1:0];
  localparam logic [W-1:0]     MAX_V = MAX64[W-1:0];

  logic w_is_min;

  assign w_is_min = (i_s == MIN_V);
  assign o_sat    = w_is_min;
  assign o_n      = w_is_min ? MAX_V : -i_s;

endmodule

// File: rtl/twos_to_adc_offset.sv
// Two's-complement <-> offset-binary converter with optional
// saturating inversion and a registered valid qualifier.
module twos_to_adc_offset
  import twos_to_adc_offset_pkg::*;
#(
  parameter int WIRE_WIDTH = 14,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  dir,
  input  logic                  invert,
  input  logic [WIRE_WIDTH-1:0] data_in,
  output logic [WIRE_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  sat
);

  localparam int W = WIRE_WIDTH;
  localparam logic [MAX_W-1:0] MSB64 = msb_flip('0, W);
  localparam logic [W-1:0]     MSB   = MSB64[W-1:0];

  logic [W-1:0] w_s;
  logic [W-1:0] w_neg;
  logic         w_neg_sat;
  logic [W-1:0] w_n;
  logic         w_sat;
  logic [W-1:0] w_res;
  logic         r_valid;

  assign w_s = (dir == DIR_TO_TWOS) ? (data_in ^ MSB) : data_in;

  twos_to_adc_offset_sat_negate #(
    .W (W)
  ) u_neg (
    .i_s   (w_s),
    .o_n   (w_neg),
    .o_sat (w_neg_sat)
  );

  assign w_n   = invert ? w_neg : w_s;
  assign w_sat = invert & w_neg_sat;
  assign w_res = (dir == DIR_TO_TWOS) ? w_n : (w_n ^ MSB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= 1'b0;
    else        r_valid <= in_valid;
  end

  assign out_valid = r_valid;

  if (REGISTERED) begin : g_reg
    logic [W-1:0] r_data;
    logic         r_sat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data <= '0;
        r_sat  <= 1'b0;
      end else if (in_valid) begin
        r_data <= w_res;
        r_sat  <= w_sat;
      end else begin
        r_sat  <= 1'b0;
      end
    end

    assign data_out = r_data;
    assign sat      = r_sat;
  end else begin : g_comb
    assign data_out = w_res;
    assign sat      = w_sat;
  end

endmodule

// File: tb/tb_twos_to_adc_offset.sv
// Directed and round-trip bench for twos_to_adc_offset (W=12).
// A second combinational instance decodes the first one's output.
module tb_twos_to_adc_offset;

  localparam int W = 12;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         dir;
  logic         invert;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         sat;
  logic [W-1:0] rt_out;
  logic         rt_valid;
  logic         rt_sat;

  int n_chk;
  int n_fail;

  twos_to_adc_offset #(
    .WIRE_WIDTH (W),
    .REGISTERED (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .dir       (dir),
    .invert    (invert),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .sat       (sat)
  );

  twos_to_adc_offset #(
    .WIRE_WIDTH (W),
    .REGISTERED (1'b0)
  ) dut_rt (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (out_valid),
    .dir       (1'b1),
    .invert    (1'b0),
    .data_in   (data_out),
    .data_out  (rt_out),
    .out_valid (rt_valid),
    .sat       (rt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] v1_in  [6] = '{12'h000, 12'h001, 12'h7FF,
                               12'hFFF, 12'hCA3, 12'hA10};
  logic [W-1:0] v1_exp [6] = '{12'h800, 12'h801, 12'hFFF,
                               12'h7FF, 12'h4A3, 12'h210};
  logic [W-1:0] v2_in  [3] = '{12'h800, 12'h000, 12'hFFF};
  logic [W-1:0] v2_exp [3] = '{12'h000, 12'h800, 12'h7FF};
  logic [W-1:0] v3_in  [3] = '{12'h001, 12'h800, 12'h7FF};
  logic [W-1:0] v3_exp [3] = '{12'h7FF, 12'hFFF, 12'h001};
  logic         v3_sat [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    logic [W-1:0] d;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dir      = 1'b0;
    invert   = 1'b0;
    data_in  = '0;
    #12;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sat", 32'(sat), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(1'b1, v1_in[i]);
      chk("t1_data", 32'(data_out), 32'(v1_exp[i]));
      chk("t1_valid", 32'(out_valid), 32'h1);
      chk("t1_sat", 32'(sat), 32'h0);
    end

    dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, v2_in[i]);
      chk("t2_data", 32'(data_out), 32'(v2_exp[i]));
    end
    dir = 1'b0;

    invert = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, v3_in[i]);
      chk("t3_data", 32'(data_out), 32'(v3_exp[i]));
      chk("t3_sat", 32'(sat), 32'(v3_sat[i]));
    end
    invert = 1'b0;

    send(1'b1, 12'h123);
    chk("t4_valid1", 32'(out_valid), 32'h1);
    chk("t4_data1", 32'(data_out), 32'h923);
    send(1'b0, 12'h456);
    chk("t4_valid0", 32'(out_valid), 32'h0);
    chk("t4_hold", 32'(data_out), 32'h923);
    chk("t4_sat0", 32'(sat), 32'h0);
    send(1'b1, 12'h001);
    chk("t4_valid2", 32'(out_valid), 32'h1);
    chk("t4_data2", 32'(data_out), 32'h801);

    invert = 1'b1;
    send(1'b1, 12'h800);
    chk("t5_presat", 32'(sat), 32'h1);
    invert = 1'b0;
    send(1'b1, 12'h300);
    chk("t5_pre", 32'(data_out), 32'hB00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_data", 32'(data_out), 32'h0);
    chk("t5_valid", 32'(out_valid), 32'h0);
    chk("t5_sat", 32'(sat), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 12'h777);
    chk("t5_idle", 32'(out_valid), 32'h0);
    send(1'b1, 12'h005);
    chk("t5_resume", 32'(data_out), 32'h805);
    chk("t5_rvalid", 32'(out_valid), 32'h1);

    for (int i = 0; i < 10000; i++) begin
      d = W'($urandom);
      send(1'b1, d);
      chk("t6_rt", 32'(rt_out), 32'(d));
    end
    chk("t6_rtvalid", 32'(rt_valid), 32'h1);
    chk("t6_rtsat", 32'(rt_sat), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
